// File: rtl/hazard_unit.sv
// -----------------------------------------------------------------------------
// hazard_unit
//
// Pipeline interlock for a five-stage MIPS-style core that uses Tuse/Tnew
// hazard detection and has a multi-cycle HI/LO (mult/div) unit.
//
// Data hazard: the D-stage instruction reads a register that an older
// instruction in E or M will write. The result is not yet forwardable, so the
// consumer needs it (Tuse) sooner than the producer delivers it (Tnew).
// MD hazard: the D-stage instruction touches HI/LO while the mult/div unit is
// busy, or while a mult/div is being launched from E in this same cycle.
// On either hazard the front end is frozen and a bubble enters D/E.
//
// Ports
//   clk                    sole clock, rising edge
//   reset                  asynchronous, active-low
//   D_rs_addr/D_rt_addr    D-stage source registers
//   D_rs_tuse/D_rt_tuse    cycles until each source is consumed
//   D_is_md                D instruction uses the HI/LO unit
//   E_a3/M_a3              destination register in E/M (0 = none)
//   E_tnew/M_tnew          cycles until the E/M result is available
//   E_md_start             mult/div launched from E this cycle
//   E_md_is_div            1 = div, 0 = mult (qualifies E_md_start)
//   stat_clr               synchronous clear of stall_cnt
//   stall                  freeze PC and F/D register
//   flush_E                insert bubble into D/E register
//   stall_cause            {md hazard, data hazard}
//   md_busy                HI/LO unit busy (registered)
//   stall_cnt              saturating count of stalled cycles
// -----------------------------------------------------------------------------
module hazard_unit #(
    parameter int REG_AW      = 5,
    parameter int TW          = 3,
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10,
    parameter int MDW         = 4,
    parameter int CNTW        = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [REG_AW-1:0] D_rs_addr,
    input  logic [REG_AW-1:0] D_rt_addr,
    input  logic [TW-1:0]     D_rs_tuse,
    input  logic [TW-1:0]     D_rt_tuse,
    input  logic              D_is_md,
    input  logic [REG_AW-1:0] E_a3,
    input  logic [REG_AW-1:0] M_a3,
    input  logic [TW-1:0]     E_tnew,
    input  logic [TW-1:0]     M_tnew,
    input  logic              E_md_start,
    input  logic              E_md_is_div,
    input  logic              stat_clr,
    output logic              stall,
    output logic              flush_E,
    output logic [1:0]        stall_cause,
    output logic              md_busy,
    output logic [CNTW-1:0]   stall_cnt
);

    localparam logic [MDW-1:0]  MULT_LOAD = MDW'(MULT_CYCLES);
    localparam logic [MDW-1:0]  DIV_LOAD  = DIV_CYCLES[MDW-1:0];
    localparam logic [CNTW-1:0] CNT_MAX   = {CNTW{1'b1}};

    logic [MDW-1:0]  md_cnt_q, md_cnt_d;
    logic [CNTW-1:0] stall_cnt_q, stall_cnt_d;

    logic data_e, data_m, data_haz, md_haz, stall_int;

    // ---------------------------------------------------------------------
    // Data hazards. Register 0 is never a real destination, so a zero a3
    // masks the stage out entirely.
    // ---------------------------------------------------------------------
    always_comb begin
        data_e = (E_a3 != '0) &&
                 (((E_a3 == D_rs_addr) && (D_rs_tuse < E_tnew)) ||
                  ((E_a3 == D_rt_addr) && (D_rt_tuse < E_tnew)));
        data_m = (M_a3 != '0) &&
                 (((M_a3 == D_rs_addr) && (D_rs_tuse < M_tnew)) ||
                  ((M_a3 == D_rt_addr) && (D_rt_tuse < M_tnew)));
        data_haz = data_e || data_m;
    end

    // md_busy comes only from the counter; E_md_start covers the launch
    // cycle, before the counter has been loaded.
    assign md_busy   = (md_cnt_q != '0);
    assign md_haz    = D_is_md && (md_busy || E_md_start);
    assign stall_int = data_haz || md_haz;

    assign stall       = stall_int;
    assign flush_E     = stall_int;
    assign stall_cause = {md_haz, data_haz};
    assign stall_cnt   = stall_cnt_q;

    // ---------------------------------------------------------------------
    // HI/LO busy counter. While counting, a new start is ignored (the
    // pipeline cannot legally issue one, and reloading would extend the
    // busy window of an operation already in flight).
    // ---------------------------------------------------------------------
    always_comb begin
        md_cnt_d = md_cnt_q;
        if (md_cnt_q != '0) begin
            md_cnt_d = md_cnt_q - MDW'(1);
        end else if (E_md_start) begin
            md_cnt_d = E_md_is_div ? DIV_LOAD : MULT_LOAD;
        end
    end

    // Stall statistics: clear wins over increment, saturates at all-ones.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (stat_clr) begin
            stall_cnt_d = '0;
        end else if (stall_int && (stall_cnt_q != CNT_MAX)) begin
            stall_cnt_d = stall_cnt_q + CNTW'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            md_cnt_q    <= '0;
            stall_cnt_q <= '0;
        end else begin
            md_cnt_q    <= md_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

endmodule

// File: tb/tb_hazard_unit.sv
// -----------------------------------------------------------------------------
// tb_hazard_unit
//
// Two instances share every input: one with default parameters and one with
// a 4-bit statistics counter so saturation is reachable quickly. A reference
// model (integer countdown for the HI/LO unit, integer stall counters and a
// loop over producer/consumer pairs for data hazards) predicts every output.
// -----------------------------------------------------------------------------
module tb_hazard_unit;

    logic       clk = 1'b0;
    logic       reset;
    logic [4:0] D_rs_addr, D_rt_addr, E_a3, M_a3;
    logic [2:0] D_rs_tuse, D_rt_tuse, E_tnew, M_tnew;
    logic       D_is_md, E_md_start, E_md_is_div, stat_clr;

    logic        stall, flush_E, md_busy;
    logic [1:0]  stall_cause;
    logic [31:0] stall_cnt;

    logic        stall4, flush4, md_busy4;
    logic [1:0]  cause4;
    logic [3:0]  stall_cnt4;

    int total = 0;
    int bad   = 0;

    // reference model state
    int     md_rem   = 0;
    longint cnt_ref  = 0;
    int     cnt4_ref = 0;

    always #5 clk = ~clk;

    hazard_unit dut (
        .clk(clk), .reset(reset),
        .D_rs_addr(D_rs_addr), .D_rt_addr(D_rt_addr),
        .D_rs_tuse(D_rs_tuse), .D_rt_tuse(D_rt_tuse),
        .D_is_md(D_is_md), .E_a3(E_a3), .M_a3(M_a3),
        .E_tnew(E_tnew), .M_tnew(M_tnew),
        .E_md_start(E_md_start), .E_md_is_div(E_md_is_div),
        .stat_clr(stat_clr),
        .stall(stall), .flush_E(flush_E), .stall_cause(stall_cause),
        .md_busy(md_busy), .stall_cnt(stall_cnt)
    );

    hazard_unit #(.CNTW(4)) dut4 (
        .clk(clk), .reset(reset),
        .D_rs_addr(D_rs_addr), .D_rt_addr(D_rt_addr),
        .D_rs_tuse(D_rs_tuse), .D_rt_tuse(D_rt_tuse),
        .D_is_md(D_is_md), .E_a3(E_a3), .M_a3(M_a3),
        .E_tnew(E_tnew), .M_tnew(M_tnew),
        .E_md_start(E_md_start), .E_md_is_div(E_md_is_div),
        .stat_clr(stat_clr),
        .stall(stall4), .flush_E(flush4), .stall_cause(cause4),
        .md_busy(md_busy4), .stall_cnt(stall_cnt4)
    );

    task automatic check_eq(input string tag, input longint obs, input longint exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Data hazard from first principles: any (producer, consumer) pair where
    // the producer writes a real register the consumer needs too early.
    function automatic bit ref_data_hazard();
        int dst [2];
        int tnew[2];
        int src [2];
        int tuse[2];
        bit h = 0;
        dst[0] = E_a3;      tnew[0] = E_tnew;
        dst[1] = M_a3;      tnew[1] = M_tnew;
        src[0] = D_rs_addr; tuse[0] = D_rs_tuse;
        src[1] = D_rt_addr; tuse[1] = D_rt_tuse;
        for (int p = 0; p < 2; p++)
            for (int c = 0; c < 2; c++)
                if (dst[p] != 0 && dst[p] == src[c] && tuse[c] < tnew[p])
                    h = 1;
        return h;
    endfunction

    task automatic idle_inputs();
        D_rs_addr = 0; D_rt_addr = 0; D_rs_tuse = 0; D_rt_tuse = 0;
        D_is_md = 0; E_a3 = 0; M_a3 = 0; E_tnew = 0; M_tnew = 0;
        E_md_start = 0; E_md_is_div = 0; stat_clr = 0;
    endtask

    // Called just after a rising edge with inputs already applied: checks
    // all outputs against the model, then advances model and DUT one edge.
    task automatic run_cycle();
        bit exp_data, exp_md, exp_stall;
        #1;
        exp_data  = ref_data_hazard();
        exp_md    = D_is_md && (md_rem > 0 || E_md_start);
        exp_stall = exp_data || exp_md;
        check_eq("stall",       stall,       exp_stall);
        check_eq("flush_E",     flush_E,     exp_stall);
        check_eq("stall_cause", stall_cause, {exp_md, exp_data});
        check_eq("md_busy",     md_busy,     md_rem > 0);
        check_eq("stall_cnt",   stall_cnt,   cnt_ref);
        check_eq("stall_cnt4",  stall_cnt4,  cnt4_ref);
        @(posedge clk);
        if (stat_clr) begin
            cnt_ref = 0; cnt4_ref = 0;
        end else if (exp_stall) begin
            if (cnt_ref < 64'hFFFF_FFFF) cnt_ref++;
            if (cnt4_ref < 15) cnt4_ref++;
        end
        if (md_rem > 0) md_rem--;
        else if (E_md_start) md_rem = E_md_is_div ? 10 : 5;
        #1;
    endtask

    initial begin
        int busy_seen;

        idle_inputs();
        reset = 1'b0;
        #1;
        check_eq("rst_busy", md_busy,   0);
        check_eq("rst_cnt",  stall_cnt, 0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;

        // basic E-stage data hazard and its boundary
        E_a3 = 8; E_tnew = 2; D_rs_addr = 8; D_rs_tuse = 1;
        #1;
        check_eq("req38_stall", stall,       1);
        check_eq("req38_flush", flush_E,     1);
        check_eq("req38_cause", stall_cause, 1);
        run_cycle();
        D_rs_tuse = 2;
        #1;
        check_eq("req38_nostall", stall, 0);
        run_cycle();

        // register 0 never hazards
        idle_inputs();
        M_a3 = 0; M_tnew = 3; D_rt_addr = 0; D_rt_tuse = 0;
        #1;
        check_eq("req39_r0", stall, 0);
        run_cycle();

        // mult: launch for one cycle, HI/LO consumer waiting in D
        idle_inputs();
        stat_clr = 1;
        run_cycle();
        stat_clr = 0;
        busy_seen = 0;
        for (int i = 0; i < 8; i++) begin
            D_is_md = 1;
            E_md_start = (i == 0);
            #1;
            if (md_busy) busy_seen++;
            run_cycle();
        end
        check_eq("req40_busy_cycles", busy_seen, 5);
        check_eq("req40_stall_cnt",   stall_cnt, 6);

        // div with a second start while busy: that start must be ignored
        idle_inputs();
        busy_seen = 0;
        for (int i = 0; i < 14; i++) begin
            E_md_start  = (i == 0 || i == 3);
            E_md_is_div = 1;
            #1;
            if (md_busy) busy_seen++;
            if (i == 10) check_eq("req41_busy_at10",  md_busy, 1);
            if (i == 11) check_eq("req41_idle_at11",  md_busy, 0);
            run_cycle();
        end
        check_eq("req41_busy_cycles", busy_seen, 10);

        // saturation of the 4-bit counter, then clear beats increment
        idle_inputs();
        E_a3 = 3; E_tnew = 4; D_rt_addr = 3; D_rt_tuse = 0;
        for (int i = 0; i < 20; i++) run_cycle();
        check_eq("req42_sat", stall_cnt4, 15);
        stat_clr = 1;
        run_cycle();
        stat_clr = 0;
        check_eq("req42_clr", stall_cnt4, 0);
        check_eq("req42_clr32", stall_cnt, 0);

        // async reset mid-div at md_cnt = 7
        idle_inputs();
        E_md_start = 1; E_md_is_div = 1;
        run_cycle();
        E_md_start = 0;
        E_a3 = 2; E_tnew = 3; D_rs_addr = 2; D_rs_tuse = 0;
        for (int i = 0; i < 3; i++) run_cycle();
        check_eq("req43_pre_busy", md_busy, 1);
        idle_inputs();
        D_is_md = 1;
        #2;
        reset = 1'b0;
        md_rem = 0; cnt_ref = 0; cnt4_ref = 0;
        #1;
        check_eq("req43_busy",  md_busy,   0);
        check_eq("req43_cnt",   stall_cnt, 0);
        check_eq("req43_stall", stall,     0);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        check_eq("req43_after", md_busy, 0);

        // randomized traffic over a small register space to provoke overlaps
        for (int n = 0; n < 400; n++) begin
            D_rs_addr   = 5'($urandom_range(0, 3));
            D_rt_addr   = 5'($urandom_range(0, 3));
            E_a3        = 5'($urandom_range(0, 3));
            M_a3        = 5'($urandom_range(0, 3));
            D_rs_tuse   = 3'($urandom_range(0, 7));
            D_rt_tuse   = 3'($urandom_range(0, 7));
            E_tnew      = 3'($urandom_range(0, 7));
            M_tnew      = 3'($urandom_range(0, 7));
            D_is_md     = ($urandom_range(0, 3) == 0);
            E_md_start  = ($urandom_range(0, 5) == 0);
            E_md_is_div = 1'($urandom_range(0, 1));
            stat_clr    = ($urandom_range(0, 40) == 0);
            run_cycle();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
